// File: rtl/vga_scan_vtx_feeder_if.sv
// Vertex write channel from the transform stage into the scan/vertex feeder.
interface vga_scan_vtx_feeder_if;
  logic               vtx_valid;
  logic               vtx_ready;
  logic [1:0]         vtx_idx;
  logic signed [20:0] vtx_x;
  logic signed [20:0] vtx_y;
  logic signed [20:0] vtx_z;
  logic               vtx_commit;

  modport master (
    output vtx_valid, vtx_idx, vtx_x, vtx_y, vtx_z, vtx_commit,
    input  vtx_ready
  );

  modport slave (
    input  vtx_valid, vtx_idx, vtx_x, vtx_y, vtx_z, vtx_commit,
    output vtx_ready
  );
endinterface

// File: rtl/vga_scan_vtx_feeder.sv
// VGA raster timing plus frame-stable vertex sets: shadow registers written via
// valid/ready, copied to the active outputs only at vblank entry.
module vga_scan_vtx_feeder #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_en,
  vga_scan_vtx_feeder_if.slave vtx,
  output logic signed [20:0] h_cnt_Q,
  output logic signed [20:0] v_cnt_Q,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               frame_start,
  output logic               swap_done,
  output logic signed [20:0] vtx1_X,
  output logic signed [20:0] vtx1_Y,
  output logic signed [20:0] vtx1_Z,
  output logic signed [20:0] vtx2_X,
  output logic signed [20:0] vtx2_Y,
  output logic signed [20:0] vtx2_Z,
  output logic signed [20:0] vtx3_X,
  output logic signed [20:0] vtx3_Y,
  output logic signed [20:0] vtx3_Z,
  output logic signed [20:0] vtx4_X,
  output logic signed [20:0] vtx4_Y,
  output logic signed [20:0] vtx4_Z
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef logic [20:0] cnt_t;

  localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
  localparam cnt_t HA       = cnt_t'(H_ACTIVE);
  localparam cnt_t VA       = cnt_t'(V_ACTIVE);
  localparam cnt_t VA_LAST  = cnt_t'(V_ACTIVE - 1);
  localparam cnt_t HS_START = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS_END   = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t VS_START = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS_END   = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {S_IDLE, S_PENDING} state_t;

  cnt_t   h_q, v_q, h_nxt, v_nxt;
  logic   h_wrap, v_wrap;
  logic   hs_nxt, vs_nxt, von_nxt, fs_nxt;
  logic   vblank_entry, accept, swap;
  state_t state, state_nxt;

  logic signed [20:0] sh_x  [4];
  logic signed [20:0] sh_y  [4];
  logic signed [20:0] sh_z  [4];
  logic signed [20:0] act_x [4];
  logic signed [20:0] act_y [4];
  logic signed [20:0] act_z [4];

  // Timing outputs are decoded from the next count so they register in step with it.
  always_comb begin
    h_nxt  = h_q;
    v_nxt  = v_q;
    h_wrap = (h_q == H_LAST);
    v_wrap = (v_q == V_LAST);
    if (pix_en) begin
      if (h_wrap) begin
        h_nxt = '0;
        v_nxt = v_wrap ? '0 : v_q + 1'b1;
      end else begin
        h_nxt = h_q + 1'b1;
      end
    end
    hs_nxt       = (h_nxt >= HS_START && h_nxt < HS_END) ? SYNC_POL : ~SYNC_POL;
    vs_nxt       = (v_nxt >= VS_START && v_nxt < VS_END) ? SYNC_POL : ~SYNC_POL;
    von_nxt      = (h_nxt < HA) && (v_nxt < VA);
    fs_nxt       = pix_en && h_wrap && v_wrap;
    vblank_entry = pix_en && h_wrap && (v_q == VA_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q         <= '0;
      v_q         <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      h_q         <= h_nxt;
      v_q         <= v_nxt;
      hsync       <= hs_nxt;
      vsync       <= vs_nxt;
      video_on    <= von_nxt;
      frame_start <= fs_nxt;
    end
  end

  assign h_cnt_Q = $signed(h_q);
  assign v_cnt_Q = $signed(v_q);

  // Accept and swap are exclusive: accept needs IDLE, swap needs PENDING.
  assign accept        = vtx.vtx_valid && (state == S_IDLE);
  assign swap          = vblank_entry && (state == S_PENDING);
  assign vtx.vtx_ready = (state == S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (accept && vtx.vtx_commit) state_nxt = S_PENDING;
      S_PENDING: if (vblank_entry)             state_nxt = S_IDLE;
      default:                                 state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        sh_x[i] <= '0;
        sh_y[i] <= '0;
        sh_z[i] <= '0;
      end
    end else if (accept) begin
      sh_x[vtx.vtx_idx] <= vtx.vtx_x;
      sh_y[vtx.vtx_idx] <= vtx.vtx_y;
      sh_z[vtx.vtx_idx] <= vtx.vtx_z;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        act_x[i] <= '0;
        act_y[i] <= '0;
        act_z[i] <= '0;
      end
      swap_done <= 1'b0;
    end else begin
      swap_done <= swap;
      if (swap) begin
        for (int unsigned i = 0; i < 4; i++) begin
          act_x[i] <= sh_x[i];
          act_y[i] <= sh_y[i];
          act_z[i] <= sh_z[i];
        end
      end
    end
  end

  assign vtx1_X = act_x[0];
  assign vtx1_Y = act_y[0];
  assign vtx1_Z = act_z[0];
  assign vtx2_X = act_x[1];
  assign vtx2_Y = act_y[1];
  assign vtx2_Z = act_z[1];
  assign vtx3_X = act_x[2];
  assign vtx3_Y = act_y[2];
  assign vtx3_Z = act_z[2];
  assign vtx4_X = act_x[3];
  assign vtx4_Y = act_y[3];
  assign vtx4_Z = act_z[3];

endmodule

// File: tb/tb_vga_scan_vtx_feeder.sv
// Scoreboard bench for vga_scan_vtx_feeder on a reduced 16x11 raster.
module tb_vga_scan_vtx_feeder;

  localparam int HA = 8, HFP = 2, HS = 3, HBP = 3;
  localparam int VA = 6, VFP = 2, VS = 1, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst;
  logic pix_en;
  logic signed [20:0] h_cnt_Q, v_cnt_Q;
  logic hsync, vsync, video_on, frame_start, swap_done;
  logic signed [20:0] vtx1_X, vtx1_Y, vtx1_Z, vtx2_X, vtx2_Y, vtx2_Z;
  logic signed [20:0] vtx3_X, vtx3_Y, vtx3_Z, vtx4_X, vtx4_Y, vtx4_Z;

  vga_scan_vtx_feeder_if vif ();

  vga_scan_vtx_feeder #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .vtx(vif),
    .h_cnt_Q(h_cnt_Q), .v_cnt_Q(v_cnt_Q),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .frame_start(frame_start), .swap_done(swap_done),
    .vtx1_X(vtx1_X), .vtx1_Y(vtx1_Y), .vtx1_Z(vtx1_Z),
    .vtx2_X(vtx2_X), .vtx2_Y(vtx2_Y), .vtx2_Z(vtx2_Z),
    .vtx3_X(vtx3_X), .vtx3_Y(vtx3_Y), .vtx3_Z(vtx3_Z),
    .vtx4_X(vtx4_X), .vtx4_Y(vtx4_Y), .vtx4_Z(vtx4_Z)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [251:0] v;
    int           frame;
  } exp_t;

  exp_t sbq[$];
  logic [251:0] exp_act;
  logic signed [20:0] bx[4], by[4], bz[4];

  function automatic logic [251:0] pack_dut();
    return {vtx1_X, vtx1_Y, vtx1_Z, vtx2_X, vtx2_Y, vtx2_Z,
            vtx3_X, vtx3_Y, vtx3_Z, vtx4_X, vtx4_Y, vtx4_Z};
  endfunction

  function automatic logic [251:0] pack_sh();
    return {bx[0], by[0], bz[0], bx[1], by[1], bz[1],
            bx[2], by[2], bz[2], bx[3], by[3], bz[3]};
  endfunction

  // Reference raster position, advanced independently from pix_en.
  int m_h, m_v, m_frame;
  logic m_fs;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_h <= 0; m_v <= 0; m_fs <= 1'b0; m_frame <= 0;
    end else begin
      m_fs <= 1'b0;
      if (pix_en) begin
        if (m_h == HT - 1) begin
          m_h <= 0;
          if (m_v == VT - 1) begin
            m_v <= 0; m_fs <= 1'b1; m_frame <= m_frame + 1;
          end else begin
            m_v <= m_v + 1;
          end
        end else begin
          m_h <= m_h + 1;
        end
      end
    end
  end

  bit mon_en = 1'b0;
  int cyc = 0;
  int last_fs = -1;

  always @(posedge rst) begin
    exp_act = '0;
    last_fs = -1;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      cyc++;
      chk("h_cnt", 256'(h_cnt_Q), 256'(m_h));
      chk("v_cnt", 256'(v_cnt_Q), 256'(m_v));
      chk("hsync", 256'(hsync), 256'(!(m_h >= HA + HFP && m_h < HA + HFP + HS)));
      chk("vsync", 256'(vsync), 256'(!(m_v >= VA + VFP && m_v < VA + VFP + VS)));
      chk("video_on", 256'(video_on), 256'(m_h < HA && m_v < VA));
      chk("frame_start", 256'(frame_start), 256'(m_fs));
      if (swap_done) begin
        if (sbq.size() == 0) begin
          chk("swap_unexpected", 256'(swap_done), 256'(0));
        end else begin
          e = sbq.pop_front();
          chk("swap_frame", 256'(m_frame), 256'(e.frame));
          chk("swap_h", 256'(h_cnt_Q), 256'(0));
          chk("swap_v", 256'(v_cnt_Q), 256'(VA));
          exp_act = e.v;
        end
      end
      chk("vtx_active", 256'(pack_dut()), 256'(exp_act));
      if (frame_start) begin
        if (last_fs >= 0) chk("fs_period", 256'(cyc - last_fs), 256'(FRAME));
        last_fs = cyc;
      end
    end
  end

  task automatic idle();
    vif.vtx_valid = 1'b0; vif.vtx_commit = 1'b0; vif.vtx_idx = '0;
    vif.vtx_x = '0; vif.vtx_y = '0; vif.vtx_z = '0;
  endtask

  // Drives one write across the next posedge; returns at the following negedge.
  task automatic wr(input int idx, input int x, input int y, input int z,
                    input bit commit, input bit expect_accept);
    vif.vtx_valid = 1'b1; vif.vtx_idx = 2'(idx); vif.vtx_commit = commit;
    vif.vtx_x = 21'(x); vif.vtx_y = 21'(y); vif.vtx_z = 21'(z);
    @(negedge clk);
    if (expect_accept) begin
      bx[idx] = 21'(x); by[idx] = 21'(y); bz[idx] = 21'(z);
    end
  endtask

  task automatic wait_pos(input int h, input int v);
    for (int i = 0; i < 4 * FRAME; i++) begin
      if (m_h == h && m_v == v) break;
      @(negedge clk);
    end
    chk("wait_pos_h", 256'(h_cnt_Q), 256'(h));
    chk("wait_pos_v", 256'(v_cnt_Q), 256'(v));
  endtask

  task automatic wait_swap();
    for (int i = 0; i < 3 * FRAME && sbq.size() != 0; i++) @(negedge clk);
    chk("swap_pending_left", 256'(sbq.size()), 256'(0));
  endtask

  int pe_seq[4]  = '{1, 0, 1, 0};
  int exp_seq[4] = '{1, 1, 2, 2};

  initial begin
    rst = 1'b1;
    pix_en = 1'b0;
    idle();
    for (int i = 0; i < 4; i++) begin bx[i] = '0; by[i] = '0; bz[i] = '0; end
    repeat (3) @(negedge clk);
    #1;
    chk("rst_h", 256'(h_cnt_Q), 256'(0));
    chk("rst_v", 256'(v_cnt_Q), 256'(0));
    chk("rst_hsync", 256'(hsync), 256'(1));
    chk("rst_vsync", 256'(vsync), 256'(1));
    chk("rst_video_on", 256'(video_on), 256'(1));
    chk("rst_frame_start", 256'(frame_start), 256'(0));
    chk("rst_swap_done", 256'(swap_done), 256'(0));
    chk("rst_ready", 256'(vif.vtx_ready), 256'(1));
    chk("rst_vtx", 256'(pack_dut()), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    // Enable toggling: count advances only on enabled edges.
    for (int i = 0; i < 4; i++) begin
      pix_en = pe_seq[i][0];
      @(posedge clk); #1;
      chk("pix_en_hold_h", 256'(h_cnt_Q), 256'(exp_seq[i]));
      @(negedge clk);
    end
    pix_en = 1'b1;

    // Two frames of free-running raster.
    repeat (2 * FRAME + 5) @(negedge clk);

    // Full vertex set committed mid-frame, then a write attempt while pending.
    wait_pos(0, 2);
    wr(0, 10, 20, 30, 1'b0, 1'b1);
    wr(1, -5, 7, 0, 1'b0, 1'b1);
    wr(2, 100, -100, 1, 1'b0, 1'b1);
    wr(3, 0, 0, -1, 1'b1, 1'b1);
    sbq.push_back('{v: pack_sh(), frame: m_frame});
    #1;
    chk("ready_after_commit", 256'(vif.vtx_ready), 256'(0));
    for (int i = 0; i < 5; i++) wr(0, 1, 1, 1, 1'b0, 1'b0);
    #1;
    chk("ready_while_pending", 256'(vif.vtx_ready), 256'(0));
    idle();
    wait_swap();
    #1;
    chk("ready_after_swap", 256'(vif.vtx_ready), 256'(1));

    // Commit accepted on the edge that enters vblank swaps one frame later.
    wait_pos(HT - 1, VA - 1);
    sbq.push_back('{v: '0, frame: m_frame + 1});
    wr(1, 7, 8, 9, 1'b1, 1'b1);
    sbq[0].v = pack_sh();
    idle();
    #1;
    chk("late_commit_no_swap", 256'(swap_done), 256'(0));
    chk("late_commit_ready", 256'(vif.vtx_ready), 256'(0));
    wait_swap();

    // Asynchronous reset while a commit is pending discards it.
    wait_pos(0, 3);
    wr(2, 50, 60, 70, 1'b1, 1'b1);
    idle();
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_h", 256'(h_cnt_Q), 256'(0));
    chk("arst_v", 256'(v_cnt_Q), 256'(0));
    chk("arst_vtx", 256'(pack_dut()), 256'(0));
    chk("arst_ready", 256'(vif.vtx_ready), 256'(1));
    for (int i = 0; i < 4; i++) begin bx[i] = '0; by[i] = '0; bz[i] = '0; end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2 * FRAME + 5) @(negedge clk);
    chk("final_queue", 256'(sbq.size()), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
